// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Front end of the Frankie multicycle CPU. Owns the PC, fetches instruction
//   words over a req/ack handshake into a one-entry prefetch buffer, loads the
//   IR on InstWrite and decodes it for the control unit and datapath.
//
// Ports
//   CLK, Reset             clock, asynchronous active-high reset
//   PCWrite, PCSrc[2:0]    PC update strobe and next-PC select
//   InstWrite              load IR from prefetch buffer (or bypass on ack)
//   mary_in, shelley_in    DATA_W register sources for the next PC
//   ra_in                  return address source
//   comp_flag              condition for PCSrc 110 / 111
//   imem_req, imem_addr    fetch request and address
//   imem_ack, imem_rdata   fetch data valid and word
//   OPCODE, flagbit, imm   IR[15:11], IR[10], IR[9:0] zero-extended
//   pc_out                 current PC
//   stall                  control unit must hold state
//
// Optional feature (macro IFU_PERF_CNT_EN)
//   Adds input perf_clr (synchronous clear) and output stall_count[15:0], a
//   saturating count of cycles with stall asserted.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module instruction_fetch_unit #(
  parameter int               DATA_W   = 16,
  parameter int               ADDR_W   = 16,
  parameter int               PC_STEP  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              PCWrite,
  input  logic [2:0]        PCSrc,
  input  logic              InstWrite,
  input  logic [DATA_W-1:0] mary_in,
  input  logic [DATA_W-1:0] shelley_in,
  input  logic [ADDR_W-1:0] ra_in,
  input  logic              comp_flag,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [4:0]        OPCODE,
  output logic              flagbit,
  output logic [ADDR_W-1:0] imm,
  output logic [ADDR_W-1:0] pc_out,
`ifdef IFU_PERF_CNT_EN
  input  logic              perf_clr,
  output logic [15:0]       stall_count,
`endif
  output logic              stall
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_FULL = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_req;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_buf;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_pc_sel;
  logic [ADDR_W-1:0]   w_imm;
  logic                w_redirect;
  logic                w_fetch_hit;

  // Register-file values are DATA_W wide; fit them onto the address width.
  function automatic logic [ADDR_W-1:0] fit_addr(input logic [DATA_W-1:0] d);
    return ADDR_W'(d);
  endfunction

  assign w_imm = ADDR_W'(r_ir[9:0]);

  always_comb begin
    w_pc_sel = r_pc;
    unique case (PCSrc)
      3'b000: w_pc_sel = r_pc + ADDR_W'(PC_STEP);
      3'b001: w_pc_sel = fit_addr(shelley_in);
      3'b010: w_pc_sel = w_imm;
      3'b011: w_pc_sel = ra_in;
      3'b100: w_pc_sel = fit_addr(mary_in);
      3'b101: w_pc_sel = fit_addr(shelley_in);
      3'b110: w_pc_sel = comp_flag ? w_imm : r_pc;
      3'b111: w_pc_sel = comp_flag ? fit_addr(shelley_in) : r_pc;
      default: w_pc_sel = r_pc;
    endcase
  end

  // Only a PC change counts as a redirect; a not-taken branch keeps the buffer.
  assign w_redirect  = PCWrite && (w_pc_sel != r_pc);
  // Ack for a live (non-discarded) request.
  assign w_fetch_hit = (r_state == S_REQ) && imem_ack;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_REQ: begin
        if (imem_ack) begin
          // Bypassed or redirected data never lands in the buffer.
          w_state_nxt = (InstWrite || w_redirect) ? S_REQ : S_FULL;
        end else if (w_redirect) begin
          w_state_nxt = S_DROP;
        end
      end
      S_FULL: begin
        if (InstWrite || w_redirect) w_state_nxt = S_REQ;
      end
      S_DROP: begin
        if (imem_ack) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_REQ;
      r_req   <= 1'b1;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == S_REQ);
      if (PCWrite) r_pc <= w_pc_sel;
      if (w_fetch_hit && !InstWrite) r_buf <= imem_rdata;
      // IR loads before any redirect invalidates the buffer.
      if (InstWrite) begin
        if (r_state == S_FULL) r_ir <= r_buf;
        else if (w_fetch_hit)  r_ir <= imem_rdata;
      end
    end
  end

  // In DROP the outstanding data belongs to the old PC, so it cannot satisfy
  // an InstWrite even when it arrives.
  assign stall = InstWrite &&
                 (((r_state == S_REQ) && !imem_ack) || (r_state == S_DROP));

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign pc_out    = r_pc;
  assign OPCODE    = r_ir[15:11];
  assign flagbit   = r_ir[10];
  assign imm       = w_imm;

`ifdef IFU_PERF_CNT_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_stall_count <= '0;
    end else if (perf_clr) begin
      r_stall_count <= '0;
    end else if (stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        PCWrite;
  logic [2:0]  PCSrc;
  logic        InstWrite;
  logic [15:0] mary_in;
  logic [15:0] shelley_in;
  logic [15:0] ra_in;
  logic        comp_flag;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [4:0]  OPCODE;
  logic        flagbit;
  logic [15:0] imm;
  logic [15:0] pc_out;
  logic        stall;
`ifdef IFU_PERF_CNT_EN
  logic        perf_clr;
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .InstWrite  (InstWrite),
    .mary_in    (mary_in),
    .shelley_in (shelley_in),
    .ra_in      (ra_in),
    .comp_flag  (comp_flag),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .OPCODE     (OPCODE),
    .flagbit    (flagbit),
    .imm        (imm),
    .pc_out     (pc_out),
`ifdef IFU_PERF_CNT_EN
    .perf_clr   (perf_clr),
    .stall_count(stall_count),
`endif
    .stall      (stall)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs;
    PCWrite = 1'b0; PCSrc = 3'd0; InstWrite = 1'b0;
    mary_in = 16'h0; shelley_in = 16'h0; ra_in = 16'h0; comp_flag = 1'b0;
    imem_ack = 1'b0; imem_rdata = 16'h0;
`ifdef IFU_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
  endtask

  // Leaves the caller at a falling edge with reset released.
  task automatic do_reset;
    idle_inputs();
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, ~a[15:8]};
  endfunction

  task automatic test_reset;
    do_reset();
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_req got %h exp 1", imem_req); end
    checks++; if (imem_addr !== 16'h0) begin errors++; $display("FAIL rst_addr got %h exp 0000", imem_addr); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %h exp 0", stall); end
    checks++; if ({OPCODE, flagbit, imm} !== 22'h0) begin errors++; $display("FAIL rst_ir got %h exp 0", {OPCODE, flagbit, imm}); end
    checks++; if (pc_out !== 16'h0) begin errors++; $display("FAIL rst_pc got %h exp 0000", pc_out); end
    // Reach FULL at a moved PC, then assert reset with no clock edge.
    PCWrite = 1'b1; PCSrc = 3'd0; imem_ack = 1'b1; imem_rdata = 16'hFFFF;
    @(negedge CLK);
    idle_inputs();
    imem_ack = 1'b1; imem_rdata = 16'h7001;
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req got %h exp 0", imem_req); end
    Reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL async_rst_req got %h exp 1", imem_req); end
    checks++; if (pc_out !== 16'h0) begin errors++; $display("FAIL async_rst_pc got %h exp 0000", pc_out); end
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic test_first_fetch;
    do_reset();
    #1;
    checks++; if (imem_addr !== 16'h0) begin errors++; $display("FAIL ff_addr got %h exp 0000", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    @(negedge CLK);
    imem_ack = 1'b0;
    InstWrite = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ff_stall got %h exp 0", stall); end
    @(negedge CLK);
    InstWrite = 1'b0;
    #1;
    checks++; if (OPCODE !== 5'h02) begin errors++; $display("FAIL ff_opcode got %h exp 02", OPCODE); end
    checks++; if (flagbit !== 1'b0) begin errors++; $display("FAIL ff_flag got %h exp 0", flagbit); end
    checks++; if (imm !== 16'h0234) begin errors++; $display("FAIL ff_imm got %h exp 0234", imm); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ff_rereq got %h exp 1", imem_req); end
  endtask

  task automatic test_pc_wrap;
    logic [15:0] exp_pc [4];
    exp_pc = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
    do_reset();
    PCWrite = 1'b1; PCSrc = 3'b011; ra_in = 16'hFFFA;
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      PCWrite = 1'b1; PCSrc = 3'b000;
      @(negedge CLK);
      PCWrite = 1'b0;
      #1;
      checks++; if (pc_out !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc%0d got %h exp %h", i, pc_out, exp_pc[i]); end
    end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_drop_req got %h exp 0", imem_req); end
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    @(negedge CLK);
    imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req got %h exp 1", imem_req); end
    checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL wrap_addr got %h exp 0002", imem_addr); end
  endtask

  task automatic test_stall_bypass;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      InstWrite = 1'b1; imem_ack = 1'b0;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL byp_stall%0d got %h exp 1", i, stall); end
      checks++; if (OPCODE !== 5'h0) begin errors++; $display("FAIL byp_hold%0d got %h exp 00", i, OPCODE); end
      @(negedge CLK);
    end
    imem_ack = 1'b1; imem_rdata = 16'hABCD;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL byp_ackstall got %h exp 0", stall); end
    @(negedge CLK);
    InstWrite = 1'b0; imem_ack = 1'b0;
    #1;
    checks++; if (OPCODE !== 5'h15) begin errors++; $display("FAIL byp_opcode got %h exp 15", OPCODE); end
    checks++; if (imm !== 16'h03CD) begin errors++; $display("FAIL byp_imm got %h exp 03cd", imm); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL byp_req got %h exp 1", imem_req); end
    InstWrite = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL byp_empty got %h exp 1", stall); end
    InstWrite = 1'b0;
  endtask

  task automatic test_redirect_drop;
    do_reset();
    InstWrite = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h0040;
    @(negedge CLK);
    idle_inputs();
    PCWrite = 1'b1; PCSrc = 3'b010;
    #1;
    checks++; if (imm !== 16'h0040) begin errors++; $display("FAIL rd_imm got %h exp 0040", imm); end
    @(negedge CLK);
    PCWrite = 1'b0;
    #1;
    checks++; if (pc_out !== 16'h0040) begin errors++; $display("FAIL rd_pc got %h exp 0040", pc_out); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_dropreq got %h exp 0", imem_req); end
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    @(negedge CLK);
    imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rd_req got %h exp 1", imem_req); end
    checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL rd_addr got %h exp 0040", imem_addr); end
    InstWrite = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rd_discard got %h exp 1", stall); end
    checks++; if (OPCODE !== 5'h00) begin errors++; $display("FAIL rd_ir got %h exp 00", OPCODE); end
    InstWrite = 1'b0;
  endtask

  task automatic test_cond_branch;
    do_reset();
    InstWrite = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h0010;
    @(negedge CLK);
    InstWrite = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h7777;
    @(negedge CLK);
    imem_ack = 1'b0;
    PCWrite = 1'b1; PCSrc = 3'b110; comp_flag = 1'b0;
    @(negedge CLK);
    PCWrite = 1'b0;
    #1;
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL cb_nt_pc got %h exp 0000", pc_out); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL cb_nt_kept got %h exp 0", imem_req); end
    PCWrite = 1'b1; PCSrc = 3'b110; comp_flag = 1'b1;
    @(negedge CLK);
    PCWrite = 1'b0; comp_flag = 1'b0;
    #1;
    checks++; if (pc_out !== 16'h0010) begin errors++; $display("FAIL cb_t_pc got %h exp 0010", pc_out); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL cb_t_req got %h exp 1", imem_req); end
    checks++; if (imem_addr !== 16'h0010) begin errors++; $display("FAIL cb_t_addr got %h exp 0010", imem_addr); end
    InstWrite = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cb_t_flushed got %h exp 1", stall); end
    InstWrite = 1'b0;
  endtask

`ifdef IFU_PERF_CNT_EN
  task automatic test_perf;
    do_reset();
    #1;
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL perf_rst got %0d exp 0", stall_count); end
    for (int i = 0; i < 5; i++) begin
      InstWrite = 1'b1;
      @(negedge CLK);
    end
    InstWrite = 1'b0;
    #1;
    checks++; if (stall_count !== 16'd5) begin errors++; $display("FAIL perf_cnt got %0d exp 5", stall_count); end
    perf_clr = 1'b1;
    @(negedge CLK);
    perf_clr = 1'b0;
    #1;
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL perf_clr got %0d exp 0", stall_count); end
  endtask
`endif

  // Reference: PC, IR, a queue holding at most one prefetched word, and a flag
  // marking the in-flight request as belonging to an abandoned PC.
  task automatic test_random;
    logic [15:0] m_pc, m_ir, npc, m_imm;
    logic [15:0] m_q[$];
    bit m_stale, had_buf, was_stale, redir, exp_req, exp_stall;
    do_reset();
    m_pc = 16'h0; m_ir = 16'h0; m_q.delete(); m_stale = 1'b0;
    for (int n = 0; n < 400; n++) begin
      InstWrite  = ($urandom_range(0, 2) == 0);
      PCWrite    = ($urandom_range(0, 3) == 0);
      PCSrc      = 3'($urandom);
      comp_flag  = 1'($urandom);
      mary_in    = 16'($urandom);
      shelley_in = ($urandom_range(0, 3) == 0) ? m_pc : 16'($urandom);
      ra_in      = ($urandom_range(0, 7) == 0) ? m_pc : 16'($urandom);
      if (m_q.size() == 0 && $urandom_range(0, 1) == 1) begin
        imem_ack   = 1'b1;
        imem_rdata = m_stale ? 16'($urandom) : mem_word(m_pc);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
      end
      #1;
      had_buf   = (m_q.size() != 0);
      was_stale = m_stale;
      exp_req   = !had_buf && !was_stale;
      exp_stall = InstWrite && !had_buf && (was_stale || !imem_ack);
      checks++; if (pc_out !== m_pc) begin errors++; $display("FAIL rnd_pc c%0d got %h exp %h", n, pc_out, m_pc); end
      checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req c%0d got %h exp %h", n, imem_req, exp_req); end
      if (exp_req) begin
        checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr c%0d got %h exp %h", n, imem_addr, m_pc); end
      end
      checks++; if ({OPCODE, flagbit, imm[9:0]} !== m_ir) begin errors++; $display("FAIL rnd_ir c%0d got %h exp %h", n, {OPCODE, flagbit, imm[9:0]}, m_ir); end
      checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rnd_stall c%0d got %h exp %h", n, stall, exp_stall); end

      m_imm = {6'b0, m_ir[9:0]};
      case (PCSrc)
        3'b000: npc = m_pc + 16'd2;
        3'b001: npc = shelley_in;
        3'b010: npc = m_imm;
        3'b011: npc = ra_in;
        3'b100: npc = mary_in;
        3'b101: npc = shelley_in;
        3'b110: npc = comp_flag ? m_imm : m_pc;
        default: npc = comp_flag ? shelley_in : m_pc;
      endcase
      redir = PCWrite && (npc != m_pc);
      @(posedge CLK);
      if (InstWrite && had_buf) m_ir = m_q.pop_front();
      else if (InstWrite && !was_stale && imem_ack) m_ir = imem_rdata;
      else if (!had_buf && !was_stale && imem_ack) m_q.push_back(imem_rdata);
      if (was_stale && imem_ack) m_stale = 1'b0;
      if (redir) begin
        m_q.delete();
        if (!had_buf && !was_stale && !imem_ack) m_stale = 1'b1;
      end
      if (PCWrite) m_pc = npc;
      @(negedge CLK);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_first_fetch();
    test_pc_wrap();
    test_stall_bypass();
    test_redirect_drop();
    test_cond_branch();
`ifdef IFU_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
